// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller and its decoder:
// opcode/funct constants, phase encoding, instruction classes and ALU ops.
package pipes;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned PHASE_W = 3;
    localparam int unsigned CLASS_W = 3;
    localparam int unsigned ALUOP_W = 3;

    // Opcode field values
    localparam logic [OP_W-1:0] F6_R_TYPE = 6'h00;
    localparam logic [OP_W-1:0] F6_J      = 6'h02;
    localparam logic [OP_W-1:0] F6_BEQ    = 6'h04;
    localparam logic [OP_W-1:0] F6_ADDI   = 6'h08;
    localparam logic [OP_W-1:0] F6_LW     = 6'h23;
    localparam logic [OP_W-1:0] F6_SW     = 6'h2B;

    // Funct field values (op == F6_R_TYPE)
    localparam logic [OP_W-1:0] F6_NOP    = 6'h00;
    localparam logic [OP_W-1:0] F6_ADDU   = 6'h21;
    localparam logic [OP_W-1:0] F6_SUBU   = 6'h23;
    localparam logic [OP_W-1:0] F6_AND    = 6'h24;
    localparam logic [OP_W-1:0] F6_OR     = 6'h25;
    localparam logic [OP_W-1:0] F6_SLT    = 6'h2A;

    // Instruction phases; FETCH is zero so a reset register reads FETCH
    typedef enum logic [PHASE_W-1:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } phase_e;

    // Decoded instruction classes; the cleared register value is CL_NOP
    typedef enum logic [CLASS_W-1:0] {
        CL_NOP   = 3'd0,
        CL_RTYPE = 3'd1,
        CL_ADDI  = 3'd2,
        CL_LW    = 3'd3,
        CL_SW    = 3'd4,
        CL_BEQ   = 3'd5,
        CL_J     = 3'd6,
        CL_ILL   = 3'd7
    } iclass_e;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data bus request handshakes between controller and memory side.
//   i_req/i_ok : instruction fetch request / response valid
//   d_req/d_wr/d_ok : data access request / store qualifier / access complete
interface multicycle_ctrl_if;
    logic i_req;
    logic i_ok;
    logic d_req;
    logic d_wr;
    logic d_ok;

    modport master (output i_req, output d_req, output d_wr,
                    input  i_ok,  input  d_ok);
    modport slave  (input  i_req, input  d_req, input  d_wr,
                    output i_ok,  output d_ok);
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Purely combinational op/func decoder: instruction class plus ALU operation.
//   op, func : IR opcode and funct fields
//   iclass   : instruction class (CL_ILL for anything unsupported)
//   alu_op   : ALU operation implied by the instruction
module mc_decode
    import pipes::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [OP_W-1:0] func,
    output iclass_e         iclass,
    output alu_op_t         alu_op
);

    always_comb begin
        iclass = CL_ILL;
        alu_op = ALU_ADD;
        case (op)
            F6_R_TYPE: begin
                case (func)
                    F6_NOP:  iclass = CL_NOP;
                    F6_ADDU: begin iclass = CL_RTYPE; alu_op = ALU_ADD; end
                    F6_SUBU: begin iclass = CL_RTYPE; alu_op = ALU_SUB; end
                    F6_AND:  begin iclass = CL_RTYPE; alu_op = ALU_AND; end
                    F6_OR:   begin iclass = CL_RTYPE; alu_op = ALU_OR;  end
                    F6_SLT:  begin iclass = CL_RTYPE; alu_op = ALU_SLT; end
                    default: iclass = CL_ILL;
                endcase
            end
            F6_ADDI: iclass = CL_ADDI;
            F6_LW:   iclass = CL_LW;
            F6_SW:   iclass = CL_SW;
            F6_BEQ:  begin iclass = CL_BEQ; alu_op = ALU_SUB; end
            F6_J:    iclass = CL_J;
            default: iclass = CL_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS sequencing controller: FETCH/DECODE/EXEC/MEM/WB phase FSM,
// bus handshakes and all datapath strobes.
//   clk, reset       : clock, asynchronous active-high reset
//   op, func         : IR fields (stable from DECODE to end of instruction)
//   alu_zero         : ALU zero flag, used by BEQ in EXEC
//   bus              : i_req/i_ok, d_req/d_wr/d_ok handshakes
//   ir_we .. alu_op  : datapath strobes (combinational)
//   state            : current phase (debug)
//   done, illegal    : end-of-instruction / unsupported-instruction pulses
//   instret          : retired-instruction counter, wraps
module multicycle_ctrl
    import pipes::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     op,
    input  logic [OP_W-1:0]     func,
    input  logic                alu_zero,
    multicycle_ctrl_if.master   bus,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic                rf_we,
    output logic                rf_dst,
    output logic                wb_sel,
    output logic                alu_srcb,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [PHASE_W-1:0]  state,
    output logic                done,
    output logic                illegal,
    output logic [CNT_W-1:0]    instret
);

    localparam logic [PHASE_W-1:0] ST_FETCH  = FETCH;
    localparam logic [PHASE_W-1:0] ST_DECODE = DECODE;
    localparam logic [PHASE_W-1:0] ST_EXEC   = EXEC;
    localparam logic [PHASE_W-1:0] ST_MEM    = MEM;
    localparam logic [PHASE_W-1:0] ST_WB     = WB;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_J   = 2'd2;

    logic [PHASE_W-1:0] state_q,   state_d;
    iclass_e            class_q,   class_d;
    logic [CNT_W-1:0]   instret_q, instret_d;

    iclass_e dec_class;
    alu_op_t dec_alu_op;

    logic i_req_c, d_req_c, d_wr_c;

    mc_decode u_decode (
        .op     (op),
        .func   (func),
        .iclass (dec_class),
        .alu_op (dec_alu_op)
    );

    // State, latched class and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            class_q   <= CL_NOP;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            instret_q <= instret_d;
        end
    end

    // Next-state and strobe generation
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        instret_d = instret_q;
        i_req_c   = 1'b0;
        d_req_c   = 1'b0;
        d_wr_c    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SRC_SEQ;
        rf_we     = 1'b0;
        rf_dst    = 1'b0;
        wb_sel    = 1'b0;
        alu_srcb  = 1'b0;
        alu_op    = ALU_ADD;
        done      = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                i_req_c = 1'b1;
                if (bus.i_ok) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                class_d = dec_class;
                case (dec_class)
                    CL_J: begin
                        pc_we   = 1'b1;
                        pc_src  = PC_SRC_J;
                        done    = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CL_NOP: begin
                        done    = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CL_ILL: begin
                        done    = 1'b1;
                        illegal = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (class_q)
                    CL_RTYPE: begin
                        // func is still on the IR, so the live decode is valid
                        alu_op  = dec_alu_op;
                        state_d = ST_WB;
                    end
                    CL_ADDI: begin
                        alu_srcb = 1'b1;
                        state_d  = ST_WB;
                    end
                    CL_LW, CL_SW: begin
                        alu_srcb = 1'b1;
                        state_d  = ST_MEM;
                    end
                    CL_BEQ: begin
                        alu_op  = ALU_SUB;
                        pc_src  = PC_SRC_BR;
                        pc_we   = alu_zero;
                        done    = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                d_req_c = 1'b1;
                d_wr_c  = (class_q == CL_SW);
                if (bus.d_ok) begin
                    if (class_q == CL_SW) begin
                        done    = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                rf_dst  = (class_q == CL_RTYPE);
                wb_sel  = (class_q == CL_LW);
                done    = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        if (done) begin
            instret_d = instret_q + CNT_W'(1);
        end

        // Reset silences every strobe immediately, including open bus requests
        if (reset) begin
            i_req_c  = 1'b0;
            d_req_c  = 1'b0;
            d_wr_c   = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            pc_src   = PC_SRC_SEQ;
            rf_we    = 1'b0;
            rf_dst   = 1'b0;
            wb_sel   = 1'b0;
            alu_srcb = 1'b0;
            alu_op   = ALU_ADD;
            done     = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign bus.i_req = i_req_c;
    assign bus.d_req = d_req_c;
    assign bus.d_wr  = d_wr_c;
    assign state     = state_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (4-bit instret to reach wrap).
module tb_multicycle_ctrl;
    import pipes::*;

    localparam int unsigned CNT_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [5:0]        op, func;
    logic              alu_zero;
    logic              ir_we, pc_we, rf_we, rf_dst, wb_sel, alu_srcb, done, illegal;
    logic [1:0]        pc_src;
    logic [2:0]        alu_op, state;
    logic [CNT_W-1:0]  instret;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .func     (func),
        .alu_zero (alu_zero),
        .bus      (bus.master),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .pc_src   (pc_src),
        .rf_we    (rf_we),
        .rf_dst   (rf_dst),
        .wb_sel   (wb_sel),
        .alu_srcb (alu_srcb),
        .alu_op   (alu_op),
        .state    (state),
        .done     (done),
        .illegal  (illegal),
        .instret  (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs settle away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 6'h00; func = 6'h00; alu_zero = 1'b0;
        bus.i_ok = 1'b0; bus.d_ok = 1'b0;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_i_req", 32'(bus.i_req), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        step();
        reset = 1'b0; #1;
        chk("fetch_i_req", 32'(bus.i_req), 32'd1);

        // ADDU, fetch answered one cycle after request
        chk("addu_f0_ir_we", 32'(ir_we), 32'd0);
        step(); bus.i_ok = 1'b1; #1;
        chk("addu_f1_ir_we", 32'(ir_we), 32'd1);
        chk("addu_f1_pc_we", 32'(pc_we), 32'd1);
        chk("addu_f1_pc_src", 32'(pc_src), 32'd0);
        step(); op = 6'h00; func = 6'h21; #1;
        chk("addu_d_state", 32'(state), 32'd1);
        chk("addu_d_ir_we_ignored", 32'(ir_we), 32'd0);
        chk("addu_d_done", 32'(done), 32'd0);
        step(); bus.i_ok = 1'b0; #1;
        chk("addu_e_state", 32'(state), 32'd2);
        chk("addu_e_alu_op", 32'(alu_op), 32'd0);
        chk("addu_e_srcb", 32'(alu_srcb), 32'd0);
        chk("addu_e_rf_we", 32'(rf_we), 32'd0);
        step(); #1;
        chk("addu_w_state", 32'(state), 32'd4);
        chk("addu_w_rf_we", 32'(rf_we), 32'd1);
        chk("addu_w_rf_dst", 32'(rf_dst), 32'd1);
        chk("addu_w_wb_sel", 32'(wb_sel), 32'd0);
        chk("addu_w_pc_we", 32'(pc_we), 32'd0);
        chk("addu_w_done", 32'(done), 32'd1);
        chk("addu_w_instret", 32'(instret), 32'd0);
        step(); #1;
        chk("addu_post_state", 32'(state), 32'd0);
        chk("addu_post_rf_we", 32'(rf_we), 32'd0);
        chk("addu_post_instret", 32'(instret), 32'd1);

        // LW, zero-wait fetch, d_ok after three wait cycles
        bus.i_ok = 1'b1; #1;
        chk("lw_f_ir_we", 32'(ir_we), 32'd1);
        step(); bus.i_ok = 1'b0; op = 6'h23; func = 6'h00; #1;
        chk("lw_d_state", 32'(state), 32'd1);
        step(); #1;
        chk("lw_e_srcb", 32'(alu_srcb), 32'd1);
        chk("lw_e_alu_op", 32'(alu_op), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(); bus.d_ok = (i == 3); #1;
            chk("lw_m_state", 32'(state), 32'd3);
            chk("lw_m_d_req", 32'(bus.d_req), 32'd1);
            chk("lw_m_d_wr", 32'(bus.d_wr), 32'd0);
            chk("lw_m_i_req", 32'(bus.i_req), 32'd0);
        end
        step(); bus.d_ok = 1'b0; #1;
        chk("lw_w_rf_we", 32'(rf_we), 32'd1);
        chk("lw_w_wb_sel", 32'(wb_sel), 32'd1);
        chk("lw_w_rf_dst", 32'(rf_dst), 32'd0);
        chk("lw_w_d_req", 32'(bus.d_req), 32'd0);
        chk("lw_w_done", 32'(done), 32'd1);
        step(); #1;
        chk("lw_post_state", 32'(state), 32'd0);
        chk("lw_post_instret", 32'(instret), 32'd2);

        // BEQ taken then not taken
        for (int k = 0; k < 2; k++) begin
            bus.i_ok = 1'b1;
            step(); bus.i_ok = 1'b0; op = 6'h04; #1;
            chk("beq_d_state", 32'(state), 32'd1);
            step(); alu_zero = (k == 0); #1;
            chk("beq_e_state", 32'(state), 32'd2);
            chk("beq_e_pc_we", 32'(pc_we), (k == 0) ? 32'd1 : 32'd0);
            chk("beq_e_pc_src", 32'(pc_src), 32'd1);
            chk("beq_e_alu_op", 32'(alu_op), 32'd1);
            chk("beq_e_done", 32'(done), 32'd1);
            step(); alu_zero = 1'b0; #1;
            chk("beq_post_state", 32'(state), 32'd0);
        end
        chk("beq_instret", 32'(instret), 32'd4);

        // J then unsupported opcode 0x3F
        bus.i_ok = 1'b1;
        step(); bus.i_ok = 1'b0; op = 6'h02; #1;
        chk("j_d_pc_we", 32'(pc_we), 32'd1);
        chk("j_d_pc_src", 32'(pc_src), 32'd2);
        chk("j_d_done", 32'(done), 32'd1);
        chk("j_d_illegal", 32'(illegal), 32'd0);
        step(); bus.i_ok = 1'b1; #1;
        chk("j_post_state", 32'(state), 32'd0);
        step(); bus.i_ok = 1'b0; op = 6'h3F; #1;
        chk("ill_d_illegal", 32'(illegal), 32'd1);
        chk("ill_d_done", 32'(done), 32'd1);
        chk("ill_d_rf_we", 32'(rf_we), 32'd0);
        chk("ill_d_d_req", 32'(bus.d_req), 32'd0);
        step(); #1;
        chk("ill_post_illegal", 32'(illegal), 32'd0);
        chk("ill_post_state", 32'(state), 32'd0);
        chk("ill_instret", 32'(instret), 32'd6);

        // SW aborted by reset during its MEM wait
        bus.i_ok = 1'b1;
        step(); bus.i_ok = 1'b0; op = 6'h2B; #1;
        step(); #1;
        chk("sw_e_srcb", 32'(alu_srcb), 32'd1);
        step(); #1;
        chk("sw_m_d_req", 32'(bus.d_req), 32'd1);
        chk("sw_m_d_wr", 32'(bus.d_wr), 32'd1);
        chk("sw_m_done", 32'(done), 32'd0);
        #2 reset = 1'b1; #1;
        chk("sw_rst_d_req", 32'(bus.d_req), 32'd0);
        chk("sw_rst_d_wr", 32'(bus.d_wr), 32'd0);
        chk("sw_rst_state", 32'(state), 32'd0);
        chk("sw_rst_instret", 32'(instret), 32'd0);
        chk("sw_rst_i_req", 32'(bus.i_req), 32'd0);
        step(); reset = 1'b0; #1;
        chk("sw_rel_i_req", 32'(bus.i_req), 32'd1);
        chk("sw_rel_instret", 32'(instret), 32'd0);

        // 16 NOPs wrap the 4-bit counter back to zero
        for (int n = 0; n < 16; n++) begin
            bus.i_ok = 1'b1;
            step(); bus.i_ok = 1'b0; op = 6'h00; func = 6'h00; #1;
            chk("nop_done", 32'(done), 32'd1);
            chk("nop_instret", 32'(instret), 32'(n));
            step(); #1;
        end
        chk("wrap_instret", 32'(instret), 32'd0);
        chk("wrap_state", 32'(state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
